// File: rtl/if_network_ctrl.sv
// if_network_ctrl
//   Sequencer in front of if_network. Streams weights into the network's flat
//   weight memory, then runs inference timesteps: one spike vector per step is
//   presented on net_spike_in, output spikes are counted per output neuron and
//   the argmax is reported as the prediction.
//
//   Optional feature (macro IF_NETWORK_CTRL_VERIFY_EN): after a load, every
//   weight address is read back and XOR-compared with the XOR of the streamed
//   weights. The result is reported on load_err. Without the macro, load_err
//   is tied to 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   load_start, run_start    start pulses (honoured in IDLE only, load wins)
//   abort                    return to IDLE, no done pulse
//   num_steps                inference timesteps, sampled on run_start
//   wt_data/wt_valid/wt_ready     weight stream
//   spk_data/spk_valid/spk_ready  spike vector stream, one beat per step
//   net_spike_in, net_spike_out   network spike interface
//   mem_addr/mem_din/mem_wen/mem_dout  network weight memory port
//   busy, load_done, run_done  status / 1-cycle done pulses
//   pred, pred_count         argmax neuron index and its spike count
//   load_err                 weight readback mismatch
module if_network_ctrl #(
  parameter int WEIGHT_SIZE       = 32,
  parameter int NUM_INPUTS        = 4,
  parameter int NUM_LAYERS        = 1,
  // Flat vector of 32-bit neuron counts, layer 0 in the least significant word.
  parameter logic [32*NUM_LAYERS-1:0] NUM_HIDDEN_LAYER_NEURONS = {32'h1},
  parameter int LAYER_ADDR_WIDTH  = 32,
  parameter int NEURON_ADDR_WIDTH = 28,
  parameter int WEIGHT_ADDR_WIDTH = 10,
  parameter int STEP_W            = 16,
  parameter int CNT_W             = 16,
  parameter int DRAIN_CYCLES      = 4,
  localparam int NOUT   = int'(NUM_HIDDEN_LAYER_NEURONS[32*(NUM_LAYERS-1) +: 32]),
  localparam int PRED_W = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        run_start,
  input  logic                        abort,
  input  logic [STEP_W-1:0]           num_steps,
  input  logic [WEIGHT_SIZE-1:0]      wt_data,
  input  logic                        wt_valid,
  output logic                        wt_ready,
  input  logic [NUM_INPUTS-1:0]       spk_data,
  input  logic                        spk_valid,
  output logic                        spk_ready,
  output logic [NUM_INPUTS-1:0]       net_spike_in,
  input  logic [NOUT-1:0]             net_spike_out,
  output logic [LAYER_ADDR_WIDTH-1:0] mem_addr,
  output logic [WEIGHT_SIZE-1:0]      mem_din,
  output logic                        mem_wen,
  input  logic [WEIGHT_SIZE-1:0]      mem_dout,
  output logic                        busy,
  output logic                        load_done,
  output logic                        run_done,
  output logic [PRED_W-1:0]           pred,
  output logic [CNT_W-1:0]            pred_count,
  output logic                        load_err
);

  localparam int LYR_W = LAYER_ADDR_WIDTH - NEURON_ADDR_WIDTH;
  localparam int NRN_W = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;
  localparam int WT_W  = WEIGHT_ADDR_WIDTH;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_ARGMAX
`ifdef IF_NETWORK_CTRL_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  function automatic int layer_size(input int l);
    return int'(NUM_HIDDEN_LAYER_NEURONS[32*l +: 32]);
  endfunction

  function automatic int fanin(input int l);
    return (l == 0) ? NUM_INPUTS : layer_size(l - 1);
  endfunction

  state_t state, state_nxt;

  logic [LYR_W-1:0] lyr_idx, lyr_nxt;
  logic [NRN_W-1:0] nrn_idx, nrn_nxt;
  logic [WT_W-1:0]  wt_idx,  wt_nxt;
  logic             last_wt, last_nrn, last_lyr, last_beat;
  logic [LAYER_ADDR_WIDTH-1:0] cur_addr;

  logic [STEP_W-1:0] step_cnt;
  logic [DRN_W-1:0]  drain_cnt;
  logic              drain_last;
  logic [PRED_W-1:0] scan_idx, best_idx;
  logic [CNT_W-1:0]  best_cnt, scan_cnt;
  logic              scan_last, take;
  logic [CNT_W-1:0]  spk_cnt [NOUT];
  logic              load_last;
  logic              wt_hs, spk_hs;

`ifdef IF_NETWORK_CTRL_VERIFY_EN
  logic [WEIGHT_SIZE-1:0] wr_xor, rd_xor;
  logic                   rd_iss, rd_iss_last, rd_smp, rd_smp_last, iss_done;
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
  assign load_err    = 1'b0;
`endif

  assign wt_hs  = wt_valid && wt_ready;
  assign spk_hs = spk_valid && spk_ready;

  // Weight index walk: weight fastest, then neuron, then layer; wraps to 0
  // after the last weight so a readback walk can start straight away.
  always_comb begin
    last_wt   = int'(wt_idx) == fanin(int'(lyr_idx)) - 1;
    last_nrn  = int'(nrn_idx) == layer_size(int'(lyr_idx)) - 1;
    last_lyr  = int'(lyr_idx) == NUM_LAYERS - 1;
    last_beat = last_wt && last_nrn && last_lyr;
    cur_addr  = {lyr_idx, nrn_idx, wt_idx};
    wt_nxt    = wt_idx + 1'b1;
    nrn_nxt   = nrn_idx;
    lyr_nxt   = lyr_idx;
    if (last_wt) begin
      wt_nxt  = '0;
      nrn_nxt = nrn_idx + 1'b1;
      if (last_nrn) begin
        nrn_nxt = '0;
        lyr_nxt = last_lyr ? '0 : lyr_idx + 1'b1;
      end
    end
  end

  always_comb begin
    drain_last = int'(drain_cnt) == DRAIN_CYCLES - 1;
    scan_last  = int'(scan_idx) == NOUT - 1;
    scan_cnt   = spk_cnt[scan_idx];
    take       = scan_cnt > best_cnt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start)     state_nxt = S_LOAD;
          else if (run_start) state_nxt = (num_steps == '0) ? S_DRAIN : S_RUN;
        end
        S_LOAD: begin
`ifdef IF_NETWORK_CTRL_VERIFY_EN
          if (wt_hs && last_beat) state_nxt = S_VERIFY;
`else
          if (wt_hs && last_beat) state_nxt = S_IDLE;
`endif
        end
        S_RUN:    if (spk_hs && step_cnt == STEP_W'(1)) state_nxt = S_DRAIN;
        S_DRAIN:  if (drain_last) state_nxt = S_ARGMAX;
        S_ARGMAX: if (scan_last)  state_nxt = S_IDLE;
`ifdef IF_NETWORK_CTRL_VERIFY_EN
        S_VERIFY: if (rd_smp && rd_smp_last) state_nxt = S_IDLE;
`endif
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic; readies drop with abort so no beat is accepted then.
  always_comb begin
    busy      = state != S_IDLE;
    wt_ready  = (state == S_LOAD) && !abort;
    spk_ready = (state == S_RUN) && (step_cnt != '0) && !abort;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      lyr_idx      <= '0;
      nrn_idx      <= '0;
      wt_idx       <= '0;
      step_cnt     <= '0;
      drain_cnt    <= '0;
      scan_idx     <= '0;
      best_idx     <= '0;
      best_cnt     <= '0;
      for (int unsigned j = 0; j < NOUT; j++) spk_cnt[j] <= '0;
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_wen      <= 1'b0;
      net_spike_in <= '0;
      load_done    <= 1'b0;
      run_done     <= 1'b0;
      load_last    <= 1'b0;
      pred         <= '0;
      pred_count   <= '0;
`ifdef IF_NETWORK_CTRL_VERIFY_EN
      wr_xor       <= '0;
      rd_xor       <= '0;
      rd_iss       <= 1'b0;
      rd_iss_last  <= 1'b0;
      rd_smp       <= 1'b0;
      rd_smp_last  <= 1'b0;
      iss_done     <= 1'b0;
      load_err     <= 1'b0;
`endif
    end else begin
      mem_wen      <= 1'b0;
      net_spike_in <= '0;
      run_done     <= 1'b0;
      load_last    <= 1'b0;
      drain_cnt    <= '0;
      // The final write issues the cycle after its handshake; load_done
      // follows one cycle later.
      load_done    <= load_last && !abort;

`ifdef IF_NETWORK_CTRL_VERIFY_EN
      // Readback pipeline: address valid (rd_iss) -> mem_dout valid (rd_smp).
      rd_iss      <= 1'b0;
      rd_smp      <= rd_iss && !abort;
      rd_smp_last <= rd_iss_last;
      if (rd_smp && !abort) begin
        rd_xor <= rd_xor ^ mem_dout;
        if (rd_smp_last) begin
          load_err  <= (rd_xor ^ mem_dout) != wr_xor;
          load_done <= 1'b1;
        end
      end
`endif

      if (!abort && (state == S_RUN || state == S_DRAIN)) begin
        for (int unsigned j = 0; j < NOUT; j++)
          if (net_spike_out[j] && spk_cnt[j] != '1) spk_cnt[j] <= spk_cnt[j] + 1'b1;
      end

      if (!abort) begin
        case (state)
          S_IDLE: begin
            if (load_start) begin
              lyr_idx <= '0;
              nrn_idx <= '0;
              wt_idx  <= '0;
`ifdef IF_NETWORK_CTRL_VERIFY_EN
              wr_xor   <= '0;
              rd_xor   <= '0;
              iss_done <= 1'b0;
              load_err <= 1'b0;
`endif
            end else if (run_start) begin
              step_cnt <= num_steps;
              for (int unsigned j = 0; j < NOUT; j++) spk_cnt[j] <= '0;
            end
          end
          S_LOAD: begin
            if (wt_hs) begin
              mem_wen  <= 1'b1;
              mem_addr <= cur_addr;
              mem_din  <= wt_data;
              lyr_idx  <= lyr_nxt;
              nrn_idx  <= nrn_nxt;
              wt_idx   <= wt_nxt;
`ifdef IF_NETWORK_CTRL_VERIFY_EN
              wr_xor   <= wr_xor ^ wt_data;
`else
              if (last_beat) load_last <= 1'b1;
`endif
            end
          end
          S_RUN: begin
            if (spk_hs) begin
              net_spike_in <= spk_data;
              step_cnt     <= step_cnt - 1'b1;
            end
          end
          S_DRAIN: begin
            drain_cnt <= drain_cnt + 1'b1;
            if (drain_last) begin
              scan_idx <= '0;
              best_idx <= '0;
              best_cnt <= '0;
            end
          end
          S_ARGMAX: begin
            if (take) begin
              best_idx <= scan_idx;
              best_cnt <= scan_cnt;
            end
            scan_idx <= scan_idx + 1'b1;
            if (scan_last) begin
              pred       <= take ? scan_idx : best_idx;
              pred_count <= take ? scan_cnt : best_cnt;
              run_done   <= 1'b1;
            end
          end
`ifdef IF_NETWORK_CTRL_VERIFY_EN
          S_VERIFY: begin
            if (!iss_done) begin
              mem_addr    <= cur_addr;
              lyr_idx     <= lyr_nxt;
              nrn_idx     <= nrn_nxt;
              wt_idx      <= wt_nxt;
              rd_iss      <= 1'b1;
              rd_iss_last <= last_beat;
              iss_done    <= last_beat;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
